// File: rtl/serial_pair_serializer_msb_first.sv
// Feeds a word pair MSB-first into the serial comparator and captures its flags into a result slot.
// Optional SERIAL_CMP_RESULT_CHECK_EN adds a parallel cross-check driving res_mismatch.
module serial_pair_serializer_msb_first #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_clear,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             ser_a,
    output logic             ser_b,
    input  logic             cmp_less,
    input  logic             cmp_eq,
    input  logic             cmp_greater,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_less,
    output logic             res_eq,
    output logic             res_greater,
    output logic             res_mismatch
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, sh_a_nxt, sh_b_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ser_clear_nxt, ser_valid_nxt, ser_first_nxt, ser_last_nxt;
    logic             ser_a_nxt, ser_b_nxt;
    logic             res_valid_nxt, res_less_nxt, res_eq_nxt, res_greater_nxt;
    logic             accept, capture, consume;

    assign in_ready = (state == IDLE) && (!res_valid || res_ready);
    assign accept   = in_valid && in_ready;
    assign capture  = (state == SHIFT) && (cnt == '0);
    assign consume  = res_valid && res_ready;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sh_a        <= '0;
            sh_b        <= '0;
            cnt         <= '0;
            ser_clear   <= 1'b0;
            ser_valid   <= 1'b0;
            ser_first   <= 1'b0;
            ser_last    <= 1'b0;
            ser_a       <= 1'b0;
            ser_b       <= 1'b0;
            res_valid   <= 1'b0;
            res_less    <= 1'b0;
            res_eq      <= 1'b0;
            res_greater <= 1'b0;
        end else begin
            state       <= state_nxt;
            sh_a        <= sh_a_nxt;
            sh_b        <= sh_b_nxt;
            cnt         <= cnt_nxt;
            ser_clear   <= ser_clear_nxt;
            ser_valid   <= ser_valid_nxt;
            ser_first   <= ser_first_nxt;
            ser_last    <= ser_last_nxt;
            ser_a       <= ser_a_nxt;
            ser_b       <= ser_b_nxt;
            res_valid   <= res_valid_nxt;
            res_less    <= res_less_nxt;
            res_eq      <= res_eq_nxt;
            res_greater <= res_greater_nxt;
        end
    end

    // Serial outputs are computed one cycle ahead so they appear registered in the bit's own cycle
    always_comb begin
        state_nxt       = state;
        sh_a_nxt        = sh_a;
        sh_b_nxt        = sh_b;
        cnt_nxt         = cnt;
        ser_clear_nxt   = 1'b0;
        ser_valid_nxt   = 1'b0;
        ser_first_nxt   = 1'b0;
        ser_last_nxt    = 1'b0;
        ser_a_nxt       = 1'b0;
        ser_b_nxt       = 1'b0;
        res_valid_nxt   = res_valid;
        res_less_nxt    = res_less;
        res_eq_nxt      = res_eq;
        res_greater_nxt = res_greater;

        if (consume) begin
            res_valid_nxt   = 1'b0;
            res_less_nxt    = 1'b0;
            res_eq_nxt      = 1'b0;
            res_greater_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    sh_a_nxt      = in_a;
                    sh_b_nxt      = in_b;
                    ser_clear_nxt = 1'b1;
                    state_nxt     = LOAD;
                end
            end
            LOAD: begin
                cnt_nxt       = CNT_W'(WIDTH - 1);
                ser_valid_nxt = 1'b1;
                ser_first_nxt = 1'b1;
                ser_last_nxt  = (WIDTH == 32'd1);
                ser_a_nxt     = sh_a[WIDTH-1];
                ser_b_nxt     = sh_b[WIDTH-1];
                sh_a_nxt      = sh_a << 1;
                sh_b_nxt      = sh_b << 1;
                state_nxt     = SHIFT;
            end
            SHIFT: begin
                if (capture) begin
                    res_valid_nxt   = 1'b1;
                    res_less_nxt    = cmp_less;
                    res_eq_nxt      = cmp_eq;
                    res_greater_nxt = cmp_greater;
                    state_nxt       = IDLE;
                end else begin
                    cnt_nxt       = cnt - CNT_W'(1);
                    ser_valid_nxt = 1'b1;
                    ser_last_nxt  = (cnt == CNT_W'(1));
                    ser_a_nxt     = sh_a[WIDTH-1];
                    ser_b_nxt     = sh_b[WIDTH-1];
                    sh_a_nxt      = sh_a << 1;
                    sh_b_nxt      = sh_b << 1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SERIAL_CMP_RESULT_CHECK_EN
    logic [WIDTH-1:0] cp_a, cp_b;
    logic [2:0]       par_flags, ser_flags;
    logic             mismatch_c;

    assign par_flags  = {cp_a < cp_b, cp_a == cp_b, cp_a > cp_b};
    assign ser_flags  = {cmp_less, cmp_eq, cmp_greater};
    assign mismatch_c = !((ser_flags == 3'b100) || (ser_flags == 3'b010) || (ser_flags == 3'b001))
                        || (ser_flags != par_flags);

    // Parallel reference copy; mismatch flag follows the slot's fill/consume rules
    always_ff @(posedge clk) begin
        if (rst) begin
            cp_a         <= '0;
            cp_b         <= '0;
            res_mismatch <= 1'b0;
        end else begin
            if (accept) begin
                cp_a <= in_a;
                cp_b <= in_b;
            end
            if (capture) begin
                res_mismatch <= mismatch_c;
            end else if (consume) begin
                res_mismatch <= 1'b0;
            end
        end
    end
`else
    assign res_mismatch = 1'b0;
`endif

endmodule
